// File: rtl/nrzi_pkg.sv
// nrzi_pkg: shared NRZI framing definitions for the receive decoder and the
// encoder-side stuffing transmitter.
//   nrzi_state_t   : framer state (HUNT searching for sync, DATA assembling bytes)
//   SYNC_BYTE_DEF  : default frame-start byte, as assembled LSB-first
//   STUFF_LEN_DEF  : default run of decoded 1s after which a 0 is stuffed
package nrzi_pkg;
    typedef enum logic {HUNT, DATA} nrzi_state_t;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'h80;
    localparam int         STUFF_LEN_DEF = 6;
endpackage

// File: rtl/nrzi_bit_decode.sv
// nrzi_bit_decode: NRZI line-to-bit stage; holds the previous line level and
// reports the decoded bit for every accepted sample.
//   clk, reset  : clock, synchronous active-high reset
//   line_valid  : line_in carries a new sample
//   line_in     : NRZI line level
//   eop         : end of packet; wins over line_valid and returns to idle high
//   dec         : decoded bit (1 = no transition, 0 = transition)
//   dec_valid   : dec is meaningful this cycle
module nrzi_bit_decode (
    input  logic clk,
    input  logic reset,
    input  logic line_valid,
    input  logic line_in,
    input  logic eop,
    output logic dec,
    output logic dec_valid
);
    logic prev_line;

    assign dec       = ~(line_in ^ prev_line);
    assign dec_valid = line_valid & ~eop;

    always_ff @(posedge clk) begin
        if (reset || eop)
            prev_line <= 1'b1;
        else if (line_valid)
            prev_line <= line_in;
    end
endmodule

// File: rtl/nrzi_rx_decoder.sv
// nrzi_rx_decoder: NRZI receive framer; hunts for the sync byte, removes
// stuffed zeros and assembles LSB-first bytes, flagging stuffing and alignment
// errors.
//   clk, reset    : clock, synchronous active-high reset
//   line_valid    : line_in carries a new sample
//   line_in       : NRZI line level
//   eop           : end-of-packet strobe (priority over line_valid)
//   byte_valid    : one-cycle pulse, byte_data holds a new byte
//   byte_data     : last completed byte
//   frame_active  : high while in DATA
//   frame_done    : one-cycle pulse on eop accepted in DATA
//   stuff_err     : one-cycle pulse on a 1 where a stuffed 0 was due
//   align_err     : one-cycle pulse when eop ends a partial byte
module nrzi_rx_decoder
    import nrzi_pkg::*;
#(
    parameter int         STUFF_LEN = STUFF_LEN_DEF,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       line_valid,
    input  logic       line_in,
    input  logic       eop,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_active,
    output logic       frame_done,
    output logic       stuff_err,
    output logic       align_err
);
    nrzi_state_t state;
    logic [7:0]  hunt, data_sr, hunt_nxt, sr_nxt;
    logic [2:0]  bit_cnt;
    logic [3:0]  ones_cnt;
    logic        dec, dec_valid, stuff_due;

    nrzi_bit_decode u_bit (
        .clk       (clk),
        .reset     (reset),
        .line_valid(line_valid),
        .line_in   (line_in),
        .eop       (eop),
        .dec       (dec),
        .dec_valid (dec_valid)
    );

    always_comb begin
        hunt_nxt  = {dec, hunt[7:1]};
        sr_nxt    = {dec, data_sr[7:1]};
        stuff_due = ones_cnt == 4'(STUFF_LEN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= HUNT;
            hunt         <= '0;
            data_sr      <= '0;
            bit_cnt      <= '0;
            ones_cnt     <= '0;
            byte_valid   <= 1'b0;
            byte_data    <= '0;
            frame_active <= 1'b0;
            frame_done   <= 1'b0;
            stuff_err    <= 1'b0;
            align_err    <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_done <= 1'b0;
            stuff_err  <= 1'b0;
            align_err  <= 1'b0;
            if (eop) begin
                // A missing stuff bit at eop is tolerated: only partial bytes count.
                if (state == DATA) begin
                    frame_done   <= 1'b1;
                    align_err    <= bit_cnt != 3'd0;
                    state        <= HUNT;
                    frame_active <= 1'b0;
                    hunt         <= '0;
                end
            end else if (dec_valid) begin
                if (state == HUNT) begin
                    hunt <= hunt_nxt;
                    if (hunt_nxt == SYNC_BYTE) begin
                        state        <= DATA;
                        frame_active <= 1'b1;
                        ones_cnt     <= '0;
                        bit_cnt      <= '0;
                        data_sr      <= '0;
                    end
                end else if (stuff_due) begin
                    ones_cnt <= '0;
                    if (dec) begin
                        stuff_err    <= 1'b1;
                        state        <= HUNT;
                        frame_active <= 1'b0;
                        hunt         <= '0;
                        bit_cnt      <= '0;
                        data_sr      <= '0;
                    end
                end else begin
                    data_sr  <= sr_nxt;
                    bit_cnt  <= bit_cnt + 3'd1;
                    ones_cnt <= dec ? ones_cnt + 4'd1 : 4'd0;
                    if (bit_cnt == 3'd7) begin
                        byte_data  <= sr_nxt;
                        byte_valid <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_nrzi_rx_decoder.sv
// tb_nrzi_rx_decoder: scoreboard bench for nrzi_rx_decoder; directed frames are
// NRZI-encoded by a reference model, expected pulses are queued at stimulus time
// and a negedge monitor pops and compares whenever the DUT pulses.
module tb_nrzi_rx_decoder;
    logic       clk = 1'b0;
    logic       reset, line_valid, line_in, eop;
    logic       byte_valid, frame_active, frame_done, stuff_err, align_err;
    logic [7:0] byte_data;

    nrzi_rx_decoder dut (
        .clk         (clk),
        .reset       (reset),
        .line_valid  (line_valid),
        .line_in     (line_in),
        .eop         (eop),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .frame_active(frame_active),
        .frame_done  (frame_done),
        .stuff_err   (stuff_err),
        .align_err   (align_err)
    );

    always #5 clk = ~clk;

    // Expected pulse vector: {byte_valid, frame_done, stuff_err, align_err, byte_data}
    logic [11:0] exp_q[$];
    int          n_cmp = 0, n_err = 0;
    logic        tx_line = 1'b1;
    int          tx_ones = 0;
    bit          gap_mode = 0;
    logic        prev_act = 1'b0;

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    always @(posedge clk) prev_act <= line_valid | eop;

    always @(negedge clk) begin
        if (!reset && (byte_valid || frame_done || stuff_err || align_err)) begin
            logic [11:0] act;
            act = {byte_valid, frame_done, stuff_err, align_err, byte_valid ? byte_data : 8'h00};
            chk("pulse_after_activity", {11'd0, prev_act}, 12'd1);
            chk("bv_and_se_exclusive", {11'd0, byte_valid & stuff_err}, 12'd0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_pulse: got %h expected none", act);
            end else
                chk("scoreboard", act, exp_q.pop_front());
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic d);
        if (gap_mode && $urandom_range(0, 9) < 3) tick();
        tx_line    = d ? tx_line : ~tx_line;
        line_in    = tx_line;
        line_valid = 1'b1;
        tick();
        line_valid = 1'b0;
    endtask

    task automatic send_sync();
        logic [7:0] s;
        s = 8'h80;
        for (int i = 0; i < 8; i++) send_bit(s[i]);
        tx_ones = 0;
    endtask

    // Reference stuffer: a 0 follows every sixth consecutive data 1.
    task automatic send_data_bit(input logic d);
        send_bit(d);
        tx_ones = d ? tx_ones + 1 : 0;
        if (tx_ones == 6) begin
            send_bit(1'b0);
            tx_ones = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        exp_q.push_back({4'b1000, b});
        for (int i = 0; i < 8; i++) send_data_bit(b[i]);
    endtask

    task automatic send_eop(input logic with_sample, input logic partial);
        exp_q.push_back({3'b010, partial, 8'h00});
        eop        = 1'b1;
        line_valid = with_sample;
        line_in    = ~tx_line;
        tick();
        eop        = 1'b0;
        line_valid = 1'b0;
        tx_line    = 1'b1;
    endtask

    task automatic drain(input string name);
        repeat (3) tick();
        chk(name, 12'(exp_q.size()), 12'd0);
        exp_q.delete();
    endtask

    initial begin
        reset = 1'b1; line_valid = 1'b0; line_in = 1'b1; eop = 1'b0;
        repeat (2) tick();
        chk("reset_outputs", {byte_valid, frame_done, stuff_err, align_err, byte_data},
            12'd0);
        chk("reset_active", {11'd0, frame_active}, 12'd0);
        reset = 1'b0;
        tick();

        // Basic frame
        send_sync();
        chk("basic_active", {11'd0, frame_active}, 12'd1);
        send_byte(8'hA5);
        send_eop(1'b0, 1'b0);
        chk("basic_inactive", {11'd0, frame_active}, 12'd0);
        drain("basic_drain");

        // Stuffing across two 0xFF bytes
        send_sync();
        send_byte(8'hFF);
        send_byte(8'hFF);
        send_eop(1'b0, 1'b0);
        drain("stuff_drain");

        // Stuff violation, then recovery frame
        send_sync();
        for (int i = 0; i < 6; i++) send_bit(1'b1);
        exp_q.push_back({4'b0010, 8'h00});
        send_bit(1'b1);
        chk("viol_inactive", {11'd0, frame_active}, 12'd0);
        send_sync();
        send_byte(8'h3C);
        send_eop(1'b0, 1'b0);
        drain("viol_drain");

        // Partial byte at eop
        send_sync();
        for (int i = 0; i < 5; i++) send_bit(i[0]);
        send_eop(1'b0, 1'b1);
        drain("partial5_drain");

        // eop with a sample on the 8th bit position: the sample must be ignored
        send_sync();
        for (int i = 0; i < 7; i++) send_bit(1'b0);
        send_eop(1'b1, 1'b1);
        drain("partial7_drain");

        // Gaps on the basic frame
        gap_mode = 1;
        send_sync();
        send_byte(8'hA5);
        send_eop(1'b0, 1'b0);
        drain("gap_drain");
        gap_mode = 0;

        // Reset mid-frame
        send_sync();
        send_byte(8'h5A);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        reset = 1'b1;
        tick();
        chk("midreset_outputs", {byte_valid, frame_done, stuff_err, align_err, byte_data},
            12'd0);
        chk("midreset_active", {11'd0, frame_active}, 12'd0);
        reset   = 1'b0;
        tx_line = 1'b1;
        tick();
        send_sync();
        send_byte(8'h01);
        send_eop(1'b0, 1'b0);
        drain("midreset_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
